// File: rtl/adder_pkg.sv
// Shared constants and operation encoding for the pipelined adder/subtractor.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result stream bundle with valid/ready on each side.
interface pipelined_adder_nbit_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );

endinterface

// File: rtl/pipelined_adder_nbit_chunk_stage.sv
// One pipeline stage: CHUNK-bit ripple add of the low chunk of the operand words,
// registered with valid and load-enable.
module adder_chunk_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             valid_prev,
    input  logic [WIDTH-1:0] x_prev,
    input  logic [WIDTH-1:0] y_prev,
    input  logic             carry_prev,
    output logic             valid,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             ovf
);

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] sum;

    // Ripple of full-adder cells over the lowest chunk.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = carry_prev;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum[i]   = x_prev[i] ^ y_prev[i] ^ c[i];
            c[i + 1] = (x_prev[i] & y_prev[i]) | (c[i] & (x_prev[i] ^ y_prev[i]));
        end
    end

    // x rotates: operand A chunks shift down, finished sum chunks enter at the top,
    // so after the last stage x holds the full result in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            valid <= valid_prev;
            if (valid_prev) begin
                x     <= (x_prev >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));
                y     <= y_prev >> CHUNK;
                carry <= c[CHUNK];
                ovf   <= c[CHUNK] ^ c[CHUNK-1];
            end
        end
    end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple stage per register,
// elastic valid/ready chain so bubbles collapse and backpressure stalls cleanly.
module pipelined_adder_nbit
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_adder_nbit_if.slave  bus
);

    localparam int unsigned STAGES = (CHUNK >= 1) ? WIDTH / CHUNK : 1;

    if (CHUNK < 1) begin : g_bad_chunk
        $error("pipelined_adder_nbit: CHUNK must be >= 1");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("pipelined_adder_nbit: WIDTH must be a multiple of CHUNK");
    end

    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] carry;
    logic              ovf [STAGES];
    logic [WIDTH-1:0]  x   [STAGES];
    logic [WIDTH-1:0]  y   [STAGES];
    logic              sub_op;

    assign sub_op = (op_e'(bus.sub) == OP_SUB);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vp;
        logic             cp;
        logic [WIDTH-1:0] xp;
        logic [WIDTH-1:0] yp;

        // A stage may load unless it and every stage after it are full and the output is stalled.
        assign load[k] = bus.out_ready | ~(&valid[STAGES-1:k]);

        if (k == 0) begin : g_head
            assign vp = bus.in_valid;
            assign xp = bus.a;
            assign yp = sub_op ? ~bus.b : bus.b;
            assign cp = sub_op ? 1'b1 : bus.cin;
        end else begin : g_body
            assign vp = valid[k-1];
            assign xp = x[k-1];
            assign yp = y[k-1];
            assign cp = carry[k-1];
        end

        adder_chunk_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .load       (load[k]),
            .valid_prev (vp),
            .x_prev     (xp),
            .y_prev     (yp),
            .carry_prev (cp),
            .valid      (valid[k]),
            .x          (x[k]),
            .y          (y[k]),
            .carry      (carry[k]),
            .ovf        (ovf[k])
        );
    end

    assign bus.in_ready  = load[0] & ~rst;
    assign bus.out_valid = valid[STAGES-1];
    assign bus.s         = x[STAGES-1];
    assign bus.cout      = carry[STAGES-1];
    assign bus.ovf       = ovf[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit: directed corner cases, streaming, stall, reset flush,
// then random traffic scored against an arithmetic reference queue.
module tb_pipelined_adder_nbit;
    import adder_pkg::*;

    localparam int unsigned WIDTH  = DEF_WIDTH;
    localparam int unsigned CHUNK  = DEF_CHUNK;
    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_adder_nbit_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder_nbit #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;
    logic [17:0] exp_q [$];
    int          pop_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // {cout, ovf, s} from plain arithmetic and the signed-overflow sign rule.
    function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
        logic [16:0] full;
        logic [15:0] nb;
        logic [15:0] s;
        logic        v;
        nb = ~b;
        if (sub) full = {1'b0, a} + {1'b0, nb} + 17'd1;
        else     full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        s = full[15:0];
        if (sub) v = (a[15] != b[15]) && (s[15] != a[15]);
        else     v = (a[15] == b[15]) && (s[15] != a[15]);
        return {full[16], v, s};
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: outputs compared every cycle they are valid (covers hold under stall).
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    chk("result", {14'd0, bus.cout, bus.ovf, bus.s}, {14'd0, exp_q[0]});
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                        pop_cyc.push_back(cyc);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_op(bus.a, bus.b, bus.cin, bus.sub));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int budget = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        @(negedge clk);
        while (!bus.in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub, input logic [17:0] exp);
        int lat = 0;
        send(a, b, cin, sub);
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'(STAGES));
        chk(tag, {14'd0, bus.cout, bus.ovf, bus.s}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int budget;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_s", 32'(bus.s), 32'd0);
        chk("rst_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_dir("add_carry8", 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});
        run_dir("add_wrap",   16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
        run_dir("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
        run_dir("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        run_dir("sub_cin_ign", 16'h0005, 16'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0002});
        run_dir("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

        // Back-to-back stream, no backpressure: one result per cycle.
        pop_cyc.delete();
        base = n_out;
        for (int i = 0; i < 8; i++) send(16'(i), 16'(i), 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_count", 32'(n_out - base), 32'd8);
        if (pop_cyc.size() >= 8) chk("b2b_span", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

        // Same stream with the output stalled for 6 cycles.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i), 16'(i), 1'b0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        #1;
        chk("stall_drained", 32'(exp_q.size()), 32'd0);
        chk("stall_count", 32'(n_out - base), 32'd8);

        // Reset with three beats in flight: none may emerge.
        base = n_out;
        for (int i = 0; i < 3; i++) send(16'h1000 + 16'(i), 16'h0100, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_s", 32'(bus.s), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("rst_flush_count", 32'(n_out - base), 32'd0);

        // Random traffic with random bubbles and backpressure.
        for (int n = 0; n < 600; n++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.a         = pick();
            bus.b         = pick();
            bus.cin       = 1'($urandom);
            bus.sub       = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (STAGES + 4) @(posedge clk);
        #1;
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
